mux_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 8:1 multiplexer.
- Accepts a parallel byte over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all channels with the mux enabled.
- Samples the mux output on each channel, so the pair acts as a byte serializer.
- Reassembles the sampled bits into a loopback word so mux integrity is checkable in-system.

---
 rtl/mux_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Sequencer that sits directly upstream of an 8:1 multiplexer. A byte taken
// over a valid/ready handshake is parked on the mux data inputs, the mux select
// is stepped through all eight channels with the mux enabled, and the mux
// output is sampled once per channel. The pair therefore behaves as a byte
// serializer. The sampled bits are also reassembled into a loopback word so the
// mux path can be checked in-system.
//
// Parameters
//   DWELL      cycles each channel is held before its mux output is sampled
//              (legal range 1..15)
//   MSB_FIRST  0: scan sel 0 -> 7, 1: scan sel 7 -> 0
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_data     byte to serialize
//   in_valid    in_data valid
//   in_ready    controller can accept a byte
//   abort       synchronous frame abort (honoured only while scanning)
//   mux_din     drives mux data inputs
//   mux_sel     drives mux select
//   mux_en      drives mux enable
//   mux_out     combinational output of the mux
//   ser_bit     sampled bit
//   ser_valid   one-cycle strobe, ser_bit valid
//   frame_done  one-cycle strobe, all 8 channels sampled
//   out_word    reassembled byte, bit k = value sampled from channel k
//   busy        high while scanning or finishing a frame
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
   parameter int unsigned DWELL     = 1,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic [7:0] mux_din,
   output logic [2:0] mux_sel,
   output logic       mux_en,
   input  logic       mux_out,
   output logic       ser_bit,
   output logic       ser_valid,
   output logic       frame_done,
   output logic [7:0] out_word,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // First and last channel of a scan depend only on the scan direction.
   localparam logic [2:0] FIRST_SEL  = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] LAST_SEL   = MSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t     state;
   state_t     state_n;
   logic [3:0] dwell_cnt;
   logic [3:0] dwell_cnt_n;

   logic       in_ready_n;
   logic [7:0] mux_din_n;
   logic [2:0] mux_sel_n;
   logic       mux_en_n;
   logic       ser_bit_n;
   logic       ser_valid_n;
   logic       frame_done_n;
   logic [7:0] out_word_n;
   logic       busy_n;

   logic       handshake;
   logic       dwell_end;
   logic       last_channel;
   logic [2:0] sel_step;

   // Handshake uses the registered in_ready, so a byte can only be taken in a
   // cycle where the controller is already advertising readiness.
   assign handshake    = in_valid && in_ready;
   assign dwell_end    = (dwell_cnt == DWELL_LAST);
   assign last_channel = (mux_sel == LAST_SEL);
   assign sel_step     = MSB_FIRST ? (mux_sel - 3'd1) : (mux_sel + 3'd1);

   // Next-state and next-output logic. Every register holds by default and
   // the strobes fall back to zero, so each state only states what changes.
   always_comb begin
      state_n      = state;
      dwell_cnt_n  = dwell_cnt;
      in_ready_n   = in_ready;
      mux_din_n    = mux_din;
      mux_sel_n    = mux_sel;
      mux_en_n     = mux_en;
      ser_bit_n    = ser_bit;
      ser_valid_n  = 1'b0;
      frame_done_n = 1'b0;
      out_word_n   = out_word;
      busy_n       = busy;

      case (state)
         IDLE: begin
            in_ready_n = 1'b1;
            mux_en_n   = 1'b0;
            busy_n     = 1'b0;
            if (handshake) begin
               mux_din_n   = in_data;
               mux_sel_n   = FIRST_SEL;
               mux_en_n    = 1'b1;
               dwell_cnt_n = 4'd0;
               in_ready_n  = 1'b0;
               busy_n      = 1'b1;
               state_n     = SCAN;
            end
         end

         SCAN: begin
            if (abort) begin
               // A sample that coincides with abort is dropped entirely:
               // no strobe and no write into the loopback word.
               mux_en_n    = 1'b0;
               mux_sel_n   = 3'd0;
               dwell_cnt_n = 4'd0;
               in_ready_n  = 1'b1;
               busy_n      = 1'b0;
               state_n     = IDLE;
            end else if (dwell_end) begin
               dwell_cnt_n          = 4'd0;
               ser_bit_n            = mux_out;
               ser_valid_n          = 1'b1;
               out_word_n[mux_sel]  = mux_out;
               if (last_channel) begin
                  // Select is left on the final channel rather than wrapping,
                  // so no ninth channel is ever presented while enabled.
                  mux_en_n     = 1'b0;
                  frame_done_n = 1'b1;
                  state_n      = DONE;
               end else begin
                  mux_sel_n = sel_step;
               end
            end else begin
               dwell_cnt_n = dwell_cnt + 4'd1;
            end
         end

         DONE: begin
            // Single cycle; abort is deliberately not looked at here.
            mux_en_n   = 1'b0;
            in_ready_n = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
         end

         default: begin
            mux_en_n   = 1'b0;
            in_ready_n = 1'b0;
            busy_n     = 1'b0;
            state_n    = IDLE;
         end
      endcase
   end

   // State and output registers. Reset wins over abort and the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dwell_cnt  <= 4'd0;
         in_ready   <= 1'b0;
         mux_din    <= 8'd0;
         mux_sel    <= 3'd0;
         mux_en     <= 1'b0;
         ser_bit    <= 1'b0;
         ser_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_word   <= 8'd0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         dwell_cnt  <= dwell_cnt_n;
         in_ready   <= in_ready_n;
         mux_din    <= mux_din_n;
         mux_sel    <= mux_sel_n;
         mux_en     <= mux_en_n;
         ser_bit    <= ser_bit_n;
         ser_valid  <= ser_valid_n;
         frame_done <= frame_done_n;
         out_word   <= out_word_n;
         busy       <= busy_n;
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Two controllers are instantiated: one scanning LSB first with DWELL=1 and
// one scanning MSB first with DWELL=3. Each drives a behavioural 8:1 mux.
// Stimulus pushes the expected strobes (bit value and the cycle it must
// appear in) onto a scoreboard queue; a negedge monitor pops and compares
// whenever a DUT raises ser_valid or frame_done.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

   localparam int DW0 = 1;
   localparam int DW1 = 3;
   localparam bit MF0 = 1'b0;
   localparam bit MF1 = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data    [2];
   logic       in_valid   [2];
   logic       in_ready   [2];
   logic       abort      [2];
   logic [7:0] mux_din    [2];
   logic [2:0] mux_sel    [2];
   logic       mux_en     [2];
   logic       mux_out    [2];
   logic       ser_bit    [2];
   logic       ser_valid  [2];
   logic       frame_done [2];
   logic [7:0] out_word   [2];
   logic       busy       [2];
   bit         force_zero = 1'b0;

   typedef struct {
      int         idx;
      int         ecyc;
      bit         is_frame;
      logic [7:0] val;
   } exp_t;

   exp_t       sb[$];
   int         compared   = 0;
   int         mismatched = 0;
   int         cyc        = 0;
   logic [7:0] model_word [2];

   always #5 clk = ~clk;

   // Cycle count = number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural mux; force_zero models a stuck-at-0 mux output.
   assign mux_out[0] = force_zero ? 1'b0 : (mux_en[0] ? mux_din[0][mux_sel[0]] : 1'b0);
   assign mux_out[1] = force_zero ? 1'b0 : (mux_en[1] ? mux_din[1][mux_sel[1]] : 1'b0);

   mux_scan_ctrl #(.DWELL(DW0), .MSB_FIRST(MF0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .abort(abort[0]),
      .mux_din(mux_din[0]), .mux_sel(mux_sel[0]), .mux_en(mux_en[0]),
      .mux_out(mux_out[0]),
      .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .frame_done(frame_done[0]),
      .out_word(out_word[0]), .busy(busy[0])
   );

   mux_scan_ctrl #(.DWELL(DW1), .MSB_FIRST(MF1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .abort(abort[1]),
      .mux_din(mux_din[1]), .mux_sel(mux_sel[1]), .mux_en(mux_en[1]),
      .mux_out(mux_out[1]),
      .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .frame_done(frame_done[1]),
      .out_word(out_word[1]), .busy(busy[1])
   );

   function automatic int dw(input int i);
      return (i == 0) ? DW0 : DW1;
   endfunction

   // Channel visited at scan position j (0..7).
   function automatic int chan(input int i, input int j);
      bit mf;
      mf = (i == 0) ? MF0 : MF1;
      return mf ? (7 - j) : j;
   endfunction

   task automatic checkOutput(input string name, input int i,
                              input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, i, cyc, act, exp);
      end
   endtask

   // Pop the scoreboard head for a strobe seen on DUT i this cycle.
   task automatic checkStrobe(input int i, input bit is_frame, input logic [7:0] act);
      compared++;
      if (sb.size() > 0 && sb[0].idx == i && sb[0].ecyc == cyc && sb[0].is_frame == is_frame) begin
         if (act !== sb[0].val) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d cyc %0d: got %0h expected %0h",
                     is_frame ? "frame_word" : "ser_bit", i, cyc, act, sb[0].val);
         end
         void'(sb.pop_front());
      end else begin
         mismatched++;
         $display("[TB] FAIL unexpected_%s dut%0d cyc %0d: got strobe expected none",
                  is_frame ? "frame_done" : "ser_valid", i, cyc);
      end
   endtask

   // Monitor: flag expected strobes that never came, then match live ones.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].ecyc < cyc) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL missed_strobe dut%0d: got none expected strobe at cyc %0d",
                  sb[0].idx, sb[0].ecyc);
         void'(sb.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
         if (ser_valid[i] === 1'b1)  checkStrobe(i, 1'b0, {7'd0, ser_bit[i]});
         if (frame_done[i] === 1'b1) checkStrobe(i, 1'b1, out_word[i]);
      end
   end

   task automatic checkResetValues(input int i);
      checkOutput("rst_in_ready",   i, 32'(in_ready[i]),   32'd0);
      checkOutput("rst_mux_din",    i, 32'(mux_din[i]),    32'd0);
      checkOutput("rst_mux_sel",    i, 32'(mux_sel[i]),    32'd0);
      checkOutput("rst_mux_en",     i, 32'(mux_en[i]),     32'd0);
      checkOutput("rst_ser_bit",    i, 32'(ser_bit[i]),    32'd0);
      checkOutput("rst_ser_valid",  i, 32'(ser_valid[i]),  32'd0);
      checkOutput("rst_frame_done", i, 32'(frame_done[i]), 32'd0);
      checkOutput("rst_out_word",   i, 32'(out_word[i]),   32'd0);
      checkOutput("rst_busy",       i, 32'(busy[i]),       32'd0);
   endtask

   // Send one byte to DUT i. Called on a negedge, returns on a negedge.
   // kill_off = 0: full frame; 1..8*DWELL: abort (or reset) at edge h+kill_off;
   // 8*DWELL+1: abort raised during the DONE cycle, which must be ignored.
   // keep leaves in_valid high and returns right after the handshake.
   task automatic applyStimulus(input int i, input logic [7:0] data, input bit keep,
                                input int kill_off, input bit use_rst, output int h);
      int         d;
      int         n;
      int         budget;
      logic [7:0] eff;
      exp_t       e;
      d           = dw(i);
      in_data[i]  = data;
      in_valid[i] = 1'b1;
      budget      = 0;
      while (in_ready[i] !== 1'b1 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (in_ready[i] !== 1'b1) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL handshake_timeout dut%0d: got in_ready=0 expected 1 within 200 cycles", i);
         in_valid[i] = 1'b0;
         h = -1;
         return;
      end
      h   = cyc + 1;
      eff = force_zero ? 8'h00 : data;
      n   = 8;
      if (kill_off > 0 && kill_off <= 8 * d) n = (kill_off - 1) / d;
      for (int k = 1; k <= n; k++) begin
         e.idx      = i;
         e.ecyc     = h + d * k;
         e.is_frame = 1'b0;
         e.val      = {7'd0, eff[chan(i, k - 1)]};
         sb.push_back(e);
         model_word[i][chan(i, k - 1)] = eff[chan(i, k - 1)];
      end
      if (n == 8) begin
         e.idx      = i;
         e.ecyc     = h + 8 * d;
         e.is_frame = 1'b1;
         e.val      = model_word[i];
         sb.push_back(e);
      end
      @(negedge clk);
      if (!keep) in_valid[i] = 1'b0;
      if (keep) return;
      if (kill_off > 0 && kill_off <= 8 * d) begin
         repeat (kill_off - 1) @(negedge clk);
         if (use_rst) rst = 1'b1;
         else abort[i] = 1'b1;
         @(negedge clk);
         abort[i] = 1'b0;
         if (use_rst) begin
            checkResetValues(i);
            rst = 1'b0;
            model_word[0] = 8'd0;
            model_word[1] = 8'd0;
            @(negedge clk);
            checkOutput("rst_release_ready", i, 32'(in_ready[i]), 32'd1);
         end else begin
            checkOutput("abort_mux_en",   i, 32'(mux_en[i]),   32'd0);
            checkOutput("abort_mux_sel",  i, 32'(mux_sel[i]),  32'd0);
            checkOutput("abort_in_ready", i, 32'(in_ready[i]), 32'd1);
            checkOutput("abort_busy",     i, 32'(busy[i]),     32'd0);
            checkOutput("abort_out_word", i, 32'(out_word[i]), 32'(model_word[i]));
         end
      end else begin
         for (int c = 0; c < 8 * d; c++) begin
            checkOutput("scan_mux_sel", i, 32'(mux_sel[i]), chan(i, c / d));
            checkOutput("scan_mux_en",  i, 32'(mux_en[i]),  32'd1);
            checkOutput("scan_mux_din", i, 32'(mux_din[i]), 32'(data));
            checkOutput("scan_busy",    i, 32'(busy[i]),    32'd1);
            @(negedge clk);
         end
         checkOutput("done_mux_en",   i, 32'(mux_en[i]),   32'd0);
         checkOutput("done_busy",     i, 32'(busy[i]),     32'd1);
         checkOutput("done_out_word", i, 32'(out_word[i]), 32'(model_word[i]));
         if (kill_off == 8 * d + 1) abort[i] = 1'b1;
         @(negedge clk);
         abort[i] = 1'b0;
         checkOutput("idle_in_ready", i, 32'(in_ready[i]), 32'd1);
         checkOutput("idle_busy",     i, 32'(busy[i]),     32'd0);
         checkOutput("idle_mux_din",  i, 32'(mux_din[i]),  32'(data));
      end
   endtask

   initial begin
      int h1;
      int h2;
      int idx;
      int kill;
      for (int i = 0; i < 2; i++) begin
         in_data[i]    = 8'd0;
         in_valid[i]   = 1'b0;
         abort[i]      = 1'b0;
         model_word[i] = 8'd0;
      end

      // Reset state, then readiness on the first cycle after release.
      repeat (3) @(negedge clk);
      checkResetValues(0);
      checkResetValues(1);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 0, 32'(in_ready[0]), 32'd1);
      checkOutput("post_rst_ready", 1, 32'(in_ready[1]), 32'd1);

      // 0x93 through both scan directions / dwell settings.
      applyStimulus(0, 8'h93, 1'b0, 0, 1'b0, h1);
      checkOutput("word_0x93", 0, 32'(out_word[0]), 32'h93);
      applyStimulus(1, 8'h93, 1'b0, 0, 1'b0, h1);
      checkOutput("word_0x93", 1, 32'(out_word[1]), 32'h93);

      // in_valid held high: second byte taken 8*DWELL+2 cycles later.
      applyStimulus(0, 8'hA5, 1'b1, 0, 1'b0, h1);
      applyStimulus(0, 8'h3C, 1'b0, 0, 1'b0, h2);
      checkOutput("b2b_gap", 0, 32'(h2 - h1), 32'd10);

      // Abort on the 4th sample edge of 0xFF, then normal traffic.
      applyStimulus(0, 8'hFF, 1'b0, 4 * DW0, 1'b0, h1);
      checkOutput("abort_word_0x3f", 0, 32'(out_word[0]), 32'h3F);
      applyStimulus(0, 8'h5A, 1'b0, 0, 1'b0, h1);
      applyStimulus(1, 8'hC3, 1'b0, 4 * DW1 + 1, 1'b0, h1);

      // Reset mid-scan discards the frame.
      applyStimulus(1, 8'h6E, 1'b0, 5, 1'b1, h1);

      // Abort raised during DONE has no effect.
      applyStimulus(1, 8'h81, 1'b0, 8 * DW1 + 1, 1'b0, h1);

      // Stuck-at-0 mux: loopback word shows it, frame still completes.
      force_zero = 1'b1;
      applyStimulus(0, 8'hFF, 1'b0, 0, 1'b0, h1);
      force_zero = 1'b0;
      checkOutput("stuck0_word", 0, 32'(out_word[0]), 32'h00);

      // Randomized frames with occasional aborts.
      for (int t = 0; t < 24; t++) begin
         idx  = int'($urandom_range(0, 1));
         kill = 0;
         if ($urandom_range(0, 3) == 0) kill = int'($urandom_range(1, 8 * dw(idx) + 1));
         applyStimulus(idx, 8'($urandom), 1'b0, kill, 1'b0, h1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
